serial_adder_ctrl: RTL and testbench

- Bit-serial add/subtract engine. Time-multiplexes one FullAdder1Bit instance (a, b, cin -> sum, co) over WIDTH clock cycles, LSB first.
- Provides a start/busy/done handshake, a carry flip-flop, operand shift registers and a result register.
- Sits beside the BCD2Bin datapath as the area-cheap multi-bit adder, used by sequencers that can tolerate WIDTH-cycle latency.

---
 rtl/serial_adder_ctrl.sv | 178 +++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial add/subtract engine. A single 1-bit full adder is time-multiplexed
// over WIDTH clock cycles, LSB first. A start/busy/done handshake hands the
// operation over; sum/co/ovf are registered and hold the previous result until
// the completion edge of the next operation.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, sampled only while idle
//   sub    0: a + b + cin   1: a - b (a + ~b + 1, cin ignored)
//   a, b   operands, captured when start is accepted
//   cin    add-mode carry-in, captured with the operands
//   busy   high while an operation is in progress
//   done   one-cycle pulse, result registers were just updated
//   sum    registered result (modulo 2^WIDTH)
//   co     carry out of the MSB; in sub mode 1 = no borrow
//   ovf    signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------

module full_adder_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic co_o
);
  assign sum_o = a_i ^ b_i ^ cin_i;
  assign co_o  = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  // Counter values of the bit feeding the MSB and of the MSB itself.
  localparam logic [CNTW-1:0] CNT_PRE_MSB = CNTW'(WIDTH - 2);
  localparam logic [CNTW-1:0] CNT_MSB     = CNTW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum;
  logic             fa_co;

  full_adder_1bit u_fa (
    .a_i   (sa_q[0]),
    .b_i   (sb_q[0]),
    .cin_i (carry_q),
    .sum_o (fa_sum),
    .co_o  (fa_co)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B and force the carry-in.
          sa_d    = a;
          sb_d    = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == CNT_PRE_MSB) begin
          cmsb_d = fa_co;
        end
        if (cnt_q == CNT_MSB) begin
          // The MSB bit is added this cycle; publish the whole result at once
          // so sum/co/ovf never show a partially built value.
          sum_d   = {fa_sum, acc_q[WIDTH-1:1]};
          co_d    = fa_co;
          ovf_d   = fa_co ^ cmsb_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  // The datapath registers are reset too, so outputs are defined immediately
  // after reset and an abandoned operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode the state register directly, so they drop to 0
  // the moment reset is asserted.
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Directed bench for serial_adder_ctrl (WIDTH=8). A latency-count model
// computes each result with plain integer arithmetic and is compared against
// the DUT outputs every cycle; directed cases also check hand-computed values.
// -----------------------------------------------------------------------------

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  int n_pass  = 0;
  int n_total = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: result from integer arithmetic, timing from a latency countdown.
  // ---------------------------------------------------------------------------
  logic         m_busy, m_done, m_co, m_ovf;
  logic [W-1:0] m_sum;
  logic [W:0]   p_res;
  logic         p_ovf;
  int           m_left;

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] bb;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_co = 1'b0; m_ovf = 1'b0;
      m_left = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        {m_co, m_sum} = p_res;
        m_ovf = p_ovf;
      end
    end else if (start) begin
      bb    = sub ? ~b : b;
      p_res = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
      p_ovf = (a[W-1] == bb[W-1]) && (p_res[W-1] != a[W-1]);
      m_busy = 1'b1;
      m_left = W;
    end
  end

  // Single compare process, 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    check("cycle {busy,done,co,ovf,sum}",
          {20'd0, busy, done, co, ovf, sum},
          {20'd0, m_busy, m_done, m_co, m_ovf, m_sum});
  end

  // One directed operation with hand-computed expectations.
  task automatic run_op(input string nm, input logic s, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic ci,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int nb;
    int t;
    @(negedge clk);
    sub = s; a = av; b = bv; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    t  = 0;
    while (!done && t < 40) begin
      if (busy) nb++;
      t++;
      @(negedge clk);
    end
    check({nm, " done seen"}, {31'd0, done}, 32'd1);
    check({nm, " busy cycles"}, nb, W);
    check({nm, " sum"}, {24'd0, sum}, {24'd0, es});
    check({nm, " co"}, {31'd0, co}, {31'd0, ec});
    check({nm, " ovf"}, {31'd0, ovf}, {31'd0, eo});
    @(negedge clk);
    check({nm, " done width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    int last_t;
    int npulse;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", {20'd0, busy, done, co, ovf, sum}, 32'd0);
    rst = 1'b0;

    run_op("add 5A+3C",   1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op("add FF+01",   1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add 00+00+1", 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    run_op("sub 10-20",   1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op("sub 80-01",   1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

    // Start pulses and operand changes while busy must be ignored.
    @(negedge clk);
    sub = 1'b0; a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    ndone = 0;
    for (int i = 1; i <= 16; i++) begin
      start = (i == 3) || (i == 8);
      if (i == 3) begin
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        check("busy hold sum", {24'd0, sum}, 32'h7F);
      end
      if (done) ndone++;
      if (i == 9) check("busy ignore sum", {24'd0, sum}, 32'h46);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy ignore done count", ndone, 1);

    // Asynchronous reset in the middle of an operation (cnt = 4).
    sub = 1'b0; a = 8'h0F; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async reset outputs", {20'd0, busy, done, co, ovf, sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abandoned op no done", ndone, 0);
    run_op("post-reset 70+70", 1'b0, 8'h70, 8'h70, 1'b0, 8'hE0, 1'b0, 1'b1);

    // Continuous start: one completion every W+2 cycles.
    @(negedge clk);
    sub = 1'b0; a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    npulse = 0;
    last_t = -1;
    for (int i = 1; i <= 45; i++) begin
      if (done) begin
        npulse++;
        check("back-to-back sum", {24'd0, sum}, 32'h33);
        if (last_t >= 0) check("back-to-back period", i - last_t, W + 2);
        last_t = i;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("back-to-back pulses", npulse, 4);
    repeat (14) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
